// File: rtl/pll_phase_ctrl.sv
// rPLL bring-up sequencer: reset/lock sequencing, LOCK filtering, phase stepping
// with a settle window, and lock-loss recovery with a bounded retry budget.
module pll_phase_ctrl #(
  parameter int RESET_CYCLES  = 24,
  parameter int LOCK_TIMEOUT  = 24000,
  parameter int LOCK_FILT     = 16,
  parameter int SETTLE_CYCLES = 240,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       fault_clr,
  input  logic       ph_valid,
  input  logic [3:0] ph_val,
  output logic       ph_ready,
  output logic       pll_reset,
  output logic       pll_reset_p,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  output logic       locked,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = ($clog2(MAX_RETRIES + 2) > 2) ? $clog2(MAX_RETRIES + 2) : 2;

  typedef enum logic [2:0] {
    ST_RST, ST_WAIT_LOCK, ST_READY, ST_SETTLE, ST_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, filt_val_q;
  logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [CW-1:0]   fail_cnt_q, fail_cnt_d, fail_inc;
  logic [3:0]      psda_q, psda_d, dutyda_q, dutyda_d;
  logic            pll_reset_q, ph_ready_q, locked_q, fault_q;
  logic            lock_qual, lock_lost;

  // Run length of the synchronised LOCK level, saturating at LOCK_FILT.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    if (sync2_q != filt_val_q) begin
      filt_cnt_d = FW'(1);
    end else if (filt_cnt_q != FW'(LOCK_FILT)) begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign lock_qual = sync2_q  && (filt_cnt_d == FW'(LOCK_FILT));
  assign lock_lost = !sync2_q && (filt_cnt_d == FW'(LOCK_FILT));
  assign fail_inc  = (fail_cnt_q == CW'(MAX_RETRIES + 1)) ? fail_cnt_q : fail_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = '0;
    to_cnt_d     = '0;
    settle_cnt_d = '0;
    fail_cnt_d   = fail_cnt_q;
    psda_d       = psda_q;
    dutyda_d     = dutyda_q;
    unique case (state_q)
      ST_RST: begin
        if (rst_cnt_q == RW'(RESET_CYCLES - 1)) state_d = ST_WAIT_LOCK;
        else                                    rst_cnt_d = rst_cnt_q + 1'b1;
      end
      ST_WAIT_LOCK: begin
        // A qualification landing on the timeout cycle wins.
        if (lock_qual) begin
          state_d    = ST_READY;
          fail_cnt_d = '0;
        end else if (to_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
          fail_cnt_d = fail_inc;
          state_d    = (fail_cnt_q >= CW'(MAX_RETRIES)) ? ST_FAULT : ST_RST;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (lock_lost) begin
          state_d    = ST_RST;
          fail_cnt_d = fail_inc;
        end else if (ph_valid && (ph_val != psda_q)) begin
          psda_d   = ph_val;
          dutyda_d = ph_val + 4'd8;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (lock_lost) begin
          state_d    = ST_RST;
          fail_cnt_d = fail_inc;
        end else if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = ST_READY;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d    = ST_RST;
          fail_cnt_d = '0;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  // NOTE: sequential state is written only with <=, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      filt_val_q   <= 1'b0;
      filt_cnt_q   <= '0;
      state_q      <= ST_RST;
      rst_cnt_q    <= '0;
      to_cnt_q     <= '0;
      settle_cnt_q <= '0;
      fail_cnt_q   <= '0;
      psda_q       <= 4'h0;
      dutyda_q     <= 4'h8;
      pll_reset_q  <= 1'b1;
      ph_ready_q   <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      sync1_q      <= pll_lock;
      sync2_q      <= sync1_q;
      filt_val_q   <= sync2_q;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      to_cnt_q     <= to_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      psda_q       <= psda_d;
      dutyda_q     <= dutyda_d;
      pll_reset_q  <= (state_d == ST_RST) || (state_d == ST_FAULT);
      ph_ready_q   <= (state_d == ST_READY);
      locked_q     <= (state_d == ST_READY) || (state_d == ST_SETTLE);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign ph_ready    = ph_ready_q;
  assign pll_reset   = pll_reset_q;
  assign pll_reset_p = pll_reset_q;
  assign psda        = psda_q;
  assign dutyda      = dutyda_q;
  assign locked      = locked_q;
  assign fault       = fault_q;
  assign retry_cnt   = (fail_cnt_q > CW'(3)) ? 2'd3 : fail_cnt_q[1:0];

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: deadline/history-based reference model compared every
// cycle, directed scenarios with literal expectations, and a randomized soak.
module tb_pll_phase_ctrl;

  localparam int RC = 24;
  localparam int LT = 1200;
  localparam int LF = 16;
  localparam int SC = 240;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       rst_n, pll_lock, fault_clr, ph_valid;
  logic [3:0] ph_val;
  logic       ph_ready, pll_reset, pll_reset_p, locked, fault;
  logic [3:0] psda, dutyda;
  logic [1:0] retry_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  pll_phase_ctrl #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_FILT(LF),
    .SETTLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .fault_clr(fault_clr),
    .ph_valid(ph_valid), .ph_val(ph_val), .ph_ready(ph_ready),
    .pll_reset(pll_reset), .pll_reset_p(pll_reset_p), .psda(psda),
    .dutyda(dutyda), .locked(locked), .fault(fault), .retry_cnt(retry_cnt)
  );

  always #20 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum {M_RST, M_WAIT, M_READY, M_SETTLE, M_FAULT} mode_e;
  mode_e m_mode  = M_RST;
  int    cyc     = 0;
  int    m_enter = 0;
  int    m_fails = 0;
  int    m_psda  = 0;
  int    m_duty  = 8;
  bit    raw_q[$] = '{1'b0, 1'b0};
  bit    syn_q[$];

  function automatic bit run_of(input bit v);
    if (syn_q.size() < LF) return 1'b0;
    for (int i = 0; i < LF; i++)
      if (syn_q[syn_q.size() - 1 - i] != v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [14:0] exp_vec();
    bit rst_o = (m_mode == M_RST) || (m_mode == M_FAULT);
    int rc    = (m_fails > 3) ? 3 : m_fails;
    return {rst_o, rst_o, 4'(m_psda), 4'(m_duty),
            (m_mode == M_READY) || (m_mode == M_SETTLE), m_mode == M_FAULT,
            2'(rc), m_mode == M_READY};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = M_RST; m_enter = cyc; m_fails = 0; m_psda = 0; m_duty = 8;
      raw_q[raw_q.size() - 1] = 1'b0;
      raw_q.push_back(1'b0);
      syn_q.delete();
    end else begin
      bit hi, lo;
      int age;
      syn_q.push_back(raw_q[raw_q.size() - 2]);
      raw_q.push_back(pll_lock);
      hi  = run_of(1'b1);
      lo  = run_of(1'b0);
      age = cyc - m_enter;
      case (m_mode)
        M_RST: if (age == RC) begin m_mode = M_WAIT; m_enter = cyc; end
        M_WAIT: begin
          if (hi) begin
            m_mode = M_READY; m_fails = 0;
          end else if (age == LT) begin
            m_fails++;
            m_mode  = (m_fails > MR) ? M_FAULT : M_RST;
            m_enter = cyc;
          end
        end
        M_READY, M_SETTLE: begin
          if (lo) begin
            m_mode = M_RST; m_enter = cyc;
            if (m_fails < MR + 1) m_fails++;
          end else if (m_mode == M_READY && ph_valid && int'(ph_val) != m_psda) begin
            m_psda = int'(ph_val); m_duty = (m_psda + 8) % 16;
            m_mode = M_SETTLE; m_enter = cyc;
          end else if (m_mode == M_SETTLE && age == SC) begin
            m_mode = M_READY;
          end
        end
        M_FAULT: if (fault_clr) begin m_mode = M_RST; m_fails = 0; m_enter = cyc; end
        default: m_mode = M_RST;
      endcase
    end
    while (raw_q.size() > 4) void'(raw_q.pop_front());
    while (syn_q.size() > LF + 2) void'(syn_q.pop_front());
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [14:0] act, exp_v;
      act   = {pll_reset, pll_reset_p, psda, dutyda, locked, fault, retry_cnt, ph_ready};
      exp_v = exp_vec();
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL model_cmp cycle %0d: got %b required %b", cyc, act, exp_v);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_locked(input int budget, input string name, output int n);
    n = 0;
    while (!locked && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(locked), 1);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, falls, low_left;
    bit prev;
    logic [3:0] v;
    rst_n = 1'b0; pll_lock = 1'b0; fault_clr = 1'b0; ph_valid = 1'b0; ph_val = 4'h0;
    tick();
    chk_en = 1'b1;
    repeat (3) tick();
    check("rst_pll_reset", int'(pll_reset), 1);
    check("rst_psda", int'(psda), 0);
    check("rst_dutyda", int'(dutyda), 8);
    check("rst_flags", int'({locked, fault, ph_ready, retry_cnt}), 0);

    // Bring-up: pll_reset width and lock qualification latency.
    n = pll_reset ? 1 : 0;
    rst_n = 1'b1;
    do begin
      tick();
      if (pll_reset) n++;
    end while (pll_reset && n < 100);
    check("reset_width", n, 24);
    repeat (99) tick();
    pll_lock = 1'b1;
    wait_locked(100, "bringup_locked", n);
    check("lock_latency", n, 18);
    check("bringup_ready", int'(ph_ready), 1);
    check("bringup_retry", int'(retry_cnt), 0);

    // Phase steps, including the duty-code wrap-around.
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 4'h3 : 4'hC;
      ph_valid = 1'b1; ph_val = v;
      tick();
      ph_valid = 1'b0;
      check("step_psda", int'(psda), int'(v));
      check("step_dutyda", int'(dutyda), (k == 0) ? 11 : 4);
      n = 0;
      while (!ph_ready && n < 400) begin
        n++;
        tick();
      end
      check("settle_len", n, 240);
    end

    // Same-phase request is absorbed without a settle window.
    ph_valid = 1'b1; ph_val = 4'hC;
    tick();
    ph_valid = 1'b0;
    check("same_psda", int'(psda), 12);
    check("same_ready", int'(ph_ready), 1);

    // Short dropout is filtered; long dropout is a loss.
    pll_lock = 1'b0;
    repeat (10) tick();
    pll_lock = 1'b1;
    repeat (30) tick();
    check("glitch_locked", int'(locked), 1);
    pll_lock = 1'b0;
    repeat (20) tick();
    check("loss_locked", int'(locked), 0);
    check("loss_retry", int'(retry_cnt), 1);
    check("loss_psda", int'(psda), 12);
    check("loss_pll_reset", int'(pll_reset), 1);
    pll_lock = 1'b1;
    wait_locked(200, "relock", n);
    check("relock_retry", int'(retry_cnt), 0);

    // Loss qualifying on the same edge as a handshake drops the request.
    pll_lock = 1'b0;
    repeat (17) tick();
    check("pre_loss_ready", int'(ph_ready), 1);
    ph_valid = 1'b1; ph_val = 4'h5;
    tick();
    ph_valid = 1'b0;
    check("race_psda", int'(psda), 12);
    check("race_pll_reset", int'(pll_reset), 1);
    check("race_ready", int'(ph_ready), 0);
    pll_lock = 1'b1;
    wait_locked(200, "race_relock", n);

    // Synchronous reset in the middle of a settle window.
    ph_valid = 1'b1; ph_val = 4'($urandom_range(0, 11));
    tick();
    ph_valid = 1'b0;
    repeat ($urandom_range(5, 200)) tick();
    check("mid_settle_ready", int'(ph_ready), 0);
    rst_n = 1'b0;
    tick();
    check("abort_psda", int'(psda), 0);
    check("abort_dutyda", int'(dutyda), 8);
    check("abort_pll_reset", int'(pll_reset), 1);
    rst_n = 1'b1;
    wait_locked(200, "abort_relock", n);

    // Randomized soak: requests, stray fault_clr pulses, lock dropouts.
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      ph_valid  = ($urandom_range(0, 2) == 0);
      ph_val    = 4'($urandom_range(0, 15));
      fault_clr = ($urandom_range(0, 49) == 0);
      if (low_left > 0) begin
        low_left--;
        pll_lock = 1'b0;
      end else begin
        pll_lock = 1'b1;
        if ($urandom_range(0, 149) == 0) low_left = $urandom_range(1, 40);
      end
    end
    ph_valid = 1'b0; fault_clr = 1'b0; pll_lock = 1'b1;
    wait_locked(300, "soak_relock", n);

    // Lock never arrives: four timeouts then FAULT.
    pll_lock = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    prev = pll_reset; n = 0; falls = 0;
    while (!fault && n < 6000) begin
      tick();
      n++;
      if (prev && !pll_reset) falls++;
      prev = pll_reset;
    end
    check("fault_set", int'(fault), 1);
    check("fault_attempts", falls, 4);
    check("fault_retry", int'(retry_cnt), 3);
    check("fault_pll_reset", int'({pll_reset, pll_reset_p}), 3);
    repeat (20) tick();
    check("fault_held", int'(fault), 1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("clr_fault", int'(fault), 0);
    check("clr_retry", int'(retry_cnt), 0);
    check("clr_pll_reset", int'(pll_reset), 1);
    pll_lock = 1'b1;
    wait_locked(200, "clr_relock", n);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_phase_ctrl.md
Name: pll_phase_ctrl

Overview:
- Sequencing controller for the on-chip rPLL: 24 MHz in, 120 MHz out, dynamic phase/duty (DYN_DA_EN) enabled.
- Runs the PLL reset/lock bring-up, filters LOCK, and reports ready/locked status.
- Accepts phase-step requests from the phase detector logic and drives the PLL PSDA/DUTYDA inputs, with a settle window after each step.
- Handles lock-loss recovery with a bounded retry count. Runs in the PLL input-clock domain, never from clkout.

Parameters:
- RESET_CYCLES, 24, cycles pll_reset is held high per bring-up attempt (1 us at 24 MHz).
- LOCK_TIMEOUT, 24000, max cycles in WAIT_LOCK before the attempt fails.
- LOCK_FILT, 16, consecutive cycles LOCK must be high (to qualify) or low (to declare loss).
- SETTLE_CYCLES, 240, cycles after a PSDA change before ready returns.
- MAX_RETRIES, 3, failed attempts tolerated before FAULT.

Ports:
- clk  in  1  free-running 24 MHz PLL reference clock
- rst_n  in  1  synchronous active-low reset
- pll_lock  in  1  rPLL LOCK, asynchronous; double-flop synchronised internally
- fault_clr  in  1  single-cycle pulse; leaves FAULT and restarts bring-up
- ph_valid  in  1  phase request valid
- ph_val  in  4  requested PSDA code, 22.5 deg per LSB
- ph_ready  out  1  high when a phase request can be accepted
- pll_reset  out  1  to rPLL RESET
- pll_reset_p  out  1  to rPLL RESET_P
- psda  out  4  to rPLL PSDA
- dutyda  out  4  to rPLL DUTYDA
- locked  out  1  qualified lock status
- fault  out  1  retries exhausted
- retry_cnt  out  2  failed attempts since last success (saturating)

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=RST, pll_reset=1, pll_reset_p=1, psda=0, dutyda=4'h8.
  - locked=0, fault=0, ph_ready=0, retry_cnt=0, all counters 0.
  - Reset taking effect mid-operation aborts any state, including SETTLE, the same way.
- pll_lock passes through 2 sync flops. The filter counter counts consecutive cycles of equal synced value; any toggle restarts it.
- RST:
  - pll_reset=1 and pll_reset_p=1 for RESET_CYCLES cycles.
  - Then both go 0 and the state moves to WAIT_LOCK with the timeout counter cleared.
- WAIT_LOCK:
  - If synced lock is high for LOCK_FILT consecutive cycles: go to READY, locked=1, retry_cnt=0.
  - If the timeout counter reaches LOCK_TIMEOUT first: retry_cnt increments (saturates at 3).
  - After that increment, if retry_cnt > MAX_RETRIES go to FAULT, otherwise go to RST.
  - A lock qualification and a timeout landing on the same cycle count as a lock.
- READY:
  - ph_ready=1. A handshake occurs when ph_valid && ph_ready on a clk edge.
  - If ph_val equals the current psda: no state change; ph_ready stays 1.
  - Otherwise, on the next edge: psda<=ph_val, dutyda<=(ph_val+8) mod 16 (keeps 50% duty), state SETTLE, ph_ready=0.
  - If synced lock is low for LOCK_FILT consecutive cycles: locked=0, ph_ready=0, retry_cnt increments, go to RST. psda/dutyda are retained across the relock.
  - Loss and handshake on the same cycle: loss wins and the request is dropped. ph_ready is 0 from the next cycle.
- SETTLE:
  - ph_ready=0 for SETTLE_CYCLES cycles, then back to READY.
  - locked stays asserted during SETTLE.
  - A lock loss detected during SETTLE behaves exactly as in READY.
- FAULT:
  - fault=1, pll_reset=1, pll_reset_p=1, locked=0, ph_ready=0.
  - fault_clr moves to RST with retry_cnt=0 and fault deasserting on the next cycle.
  - fault_clr has no effect in any other state.
- ph_ready is a registered output and never depends combinationally on ph_valid.
- Every counter is sized ceil(log2(param+1)) bits and must not wrap.

Test Plan:
- Bring-up: release rst_n, pll_lock rises 100 cycles after pll_reset falls -> pll_reset high exactly 24 cycles; locked=1 and ph_ready=1 at 2 (sync) + 16 (filter) cycles after the lock rise; retry_cnt=0.
- Phase step: in READY, ph_valid with ph_val=4'h3 -> psda=3, dutyda=4'hB next cycle; ph_ready low for 240 cycles then high. Repeat with ph_val=4'hC -> dutyda=4'h4 (wrap-around).
- Same-phase request: ph_val equal to the current psda -> no SETTLE, ph_ready stays 1, psda unchanged.
- Lock glitch vs loss: 10-cycle LOCK dropout in READY -> locked stays 1. A 20-cycle dropout -> locked=0, re-enters RST, retry_cnt=1, psda retained; relock restores locked=1 with retry_cnt=0.
- Timeout/fault: hold pll_lock=0 -> four 24000-cycle timeouts, retry_cnt saturates at 3, fault=1, pll_reset=1. A fault_clr pulse -> RST, fault=0 and retry_cnt=0 the next cycle.
- Simultaneous events: loss qualification on the same cycle as a ph_valid handshake -> request dropped, psda unchanged, state RST. rst_n asserted mid-SETTLE -> psda=0, dutyda=8, pll_reset=1 the following cycle.
